// File: rtl/bus_dma_if.sv
// Bus and control bundle between the DMA engine and its environment.
// The master side is the DMA engine. The slave side is the memory bus or controller model.
interface bus_dma_if;
    logic        start;
    logic        abort;
    logic [15:0] src_address;
    logic [15:0] dst_address;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        bus_enable;
    logic        write_enable;
    logic        bus_ready;

    modport master (
        input  start, abort, src_address, dst_address, count, data_in, bus_ready,
        output busy, done, address, data_out, bus_enable, write_enable
    );

    modport slave (
        output start, abort, src_address, dst_address, count, data_in, bus_ready,
        input  busy, done, address, data_out, bus_enable, write_enable
    );
endinterface

// File: rtl/bus_dma.sv
// Single-channel block-copy DMA engine.
// The engine copies one word at a time in ascending order: a READ phase, then a WRITE phase.
// All bus and status outputs come from flops that load the values for the next state.
module bus_dma #(
    parameter int READ_LATENCY = 1
) (
    input logic      clk,
    input logic      reset,
    bus_dma_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  lat_q, lat_d;
    logic [15:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        be_q, be_d;
    logic        we_q, we_d;

    // State, datapath and registered-output flops; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            rem_q   <= 16'h0000;
            hold_q  <= 16'h0000;
            lat_q   <= 4'h0;
            addr_q  <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            be_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    // Next-state logic, then output values for the next state (abort beats bus_ready).
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        lat_d   = lat_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.count != 16'd0) begin
                        src_d   = bus.src_address;
                        dst_d   = bus.dst_address;
                        rem_d   = bus.count;
                        lat_d   = 4'h0;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (bus.abort) begin
                    lat_d   = 4'h0;
                    state_d = IDLE;
                end else if (bus.bus_ready) begin
                    if (lat_q == LAT_LAST) begin
                        hold_d  = bus.data_in;
                        lat_d   = 4'h0;
                        state_d = WRITE;
                    end else begin
                        lat_d = lat_q + 4'd1;
                    end
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.bus_ready) begin
                    src_d   = src_q + 16'd1;
                    dst_d   = dst_q + 16'd1;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? DONE : READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
        be_d   = busy_d;
        we_d   = (state_d == WRITE);
        if (state_d == READ) begin
            addr_d = src_d;
        end else if (state_d == WRITE) begin
            addr_d = dst_d;
        end else begin
            addr_d = 16'h0000;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.address      = addr_q;
    assign bus.data_out     = hold_q;
    assign bus.bus_enable   = be_q;
    assign bus.write_enable = we_q;

endmodule

// File: tb/tb_bus_dma.sv
// Randomised and directed bench for bus_dma with a word-addressed memory bus model.
module tb_bus_dma;

    localparam int LAT = 1;

    logic clk;
    logic reset;

    bus_dma_if bif ();

    bus_dma #(.READ_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    logic [15:0] mem [0:65535];
    assign bif.data_in = mem[bif.address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-run monitor state
    bit          tracing = 0;
    bit          rand_rdy = 0;
    int          stall_left = 0;
    logic [15:0] st_addr, st_data;
    int          busy_n, stall_n, be_n, done_n;
    logic [16:0] obs [$];
    logic [16:0] expq [$];
    logic [15:0] shadow [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: choose bus_ready, observe the current cycle, perform the bus write, advance.
    task automatic step();
        if (rand_rdy) bif.bus_ready = ($urandom_range(0, 3) != 0);
        else          bif.bus_ready = 1'b1;
        if (stall_left > 0 && bif.write_enable) begin
            bif.bus_ready = 1'b0;
            if (stall_left == 3) begin
                st_addr = bif.address;
                st_data = bif.data_out;
            end else begin
                chk("stall_addr", 32'(bif.address), 32'(st_addr));
                chk("stall_data", 32'(bif.data_out), 32'(st_data));
            end
            stall_left--;
        end
        if (tracing) begin
            if (bif.busy) busy_n++;
            if (bif.busy && !bif.bus_ready) stall_n++;
            if (bif.bus_enable) be_n++;
            if (bif.bus_enable && bif.bus_ready) obs.push_back({bif.write_enable, bif.address});
            if (bif.done) done_n++;
        end
        if (bif.bus_enable && bif.write_enable && bif.bus_ready && !bif.abort && reset)
            mem[bif.address] = bif.data_out;
        @(posedge clk);
        #1;
    endtask

    // Launch one copy and check its bus trace, timing and final memory contents.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c,
                            input bit rnd, input bit stall3, output int ncyc);
        logic [15:0] a, wa, v;
        int budget;
        shadow.delete();
        expq.delete();
        obs.delete();
        for (int i = 0; i < int'(c); i++) begin
            a  = s + 16'(i);
            wa = d + 16'(i);
            v  = shadow.exists(int'(a)) ? shadow[int'(a)] : mem[a];
            for (int k = 0; k < LAT; k++) expq.push_back({1'b0, a});
            expq.push_back({1'b1, wa});
            shadow[int'(wa)] = v;
        end
        busy_n = 0; stall_n = 0; be_n = 0; done_n = 0;
        rand_rdy   = rnd;
        stall_left = stall3 ? 3 : 0;
        bif.src_address = s;
        bif.dst_address = d;
        bif.count       = c;
        bif.start       = 1'b1;
        tracing         = 1;
        step();
        bif.start = 1'b0;
        ncyc   = 0;
        budget = int'(c) * (LAT + 1) * 8 + 40;
        while (done_n == 0 && ncyc < budget) begin
            step();
            ncyc++;
        end
        tracing  = 0;
        rand_rdy = 0;
        chk("done_seen", 32'(done_n), 32'd1);
        chk("copy_cycles", 32'(ncyc), 32'(int'(c) * (LAT + 1) + stall_n + 1));
        chk("busy_net", 32'(busy_n - stall_n), 32'(int'(c) * (LAT + 1)));
        chk("be_eq_busy", 32'(be_n), 32'(busy_n));
        chk("done_width", 32'(bif.done), 32'd0);
        chk("trace_len", 32'(obs.size()), 32'(expq.size()));
        for (int i = 0; i < obs.size() && i < expq.size(); i++)
            chk("trace", 32'(obs[i]), 32'(expq[i]));
        foreach (shadow[k]) chk("mem", 32'(mem[16'(k)]), 32'(shadow[k]));
    endtask

    initial begin
        int n;
        logic [15:0] s, d, c;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 16'hA001 + 16'(i);

        bif.start = 0; bif.abort = 0; bif.bus_ready = 1;
        bif.src_address = 0; bif.dst_address = 0; bif.count = 0;

        // asynchronous reset state, before any clock edge
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_be", 32'(bif.bus_enable), 32'd0);
        chk("rst_we", 32'(bif.write_enable), 32'd0);
        chk("rst_addr", 32'(bif.address), 32'd0);
        chk("rst_dout", 32'(bif.data_out), 32'd0);
        @(posedge clk); #1;
        step();
        reset = 1'b1;
        step();

        // basic copy
        run_copy(16'h0010, 16'h6000, 16'd4, 0, 0, n);
        chk("basic_cycles", 32'(n), 32'd9);
        chk("basic_busy", 32'(busy_n), 32'd8);
        for (int i = 0; i < 4; i++)
            chk("basic_mem", 32'(mem[16'h6000 + 16'(i)]), 32'(16'hA001 + 16'(i)));

        // zero count
        run_copy(16'h1234, 16'h4321, 16'd0, 0, 0, n);
        chk("zero_cycles", 32'(n), 32'd1);
        chk("zero_be", 32'(be_n), 32'd0);
        chk("zero_busy", 32'(busy_n), 32'd0);

        // address wrap
        run_copy(16'hFFFF, 16'h0100, 16'd2, 0, 0, n);

        // stall during first WRITE
        run_copy(16'h0200, 16'h0300, 16'd4, 0, 1, n);
        chk("stall_n", 32'(stall_n), 32'd3);
        chk("stall_cycles", 32'(n), 32'd12);

        // start with abort in IDLE is ignored
        bif.count = 16'd3; bif.start = 1; bif.abort = 1;
        step();
        bif.start = 0; bif.abort = 0;
        chk("sa_busy", 32'(bif.busy), 32'd0);
        chk("sa_done", 32'(bif.done), 32'd0);
        step();
        chk("sa_done2", 32'(bif.done), 32'd0);
        chk("sa_be", 32'(bif.bus_enable), 32'd0);

        // ignored restart, then abort
        bif.src_address = 16'h2000; bif.dst_address = 16'h3000; bif.count = 16'd8;
        bif.start = 1;
        step();
        bif.start = 0;
        step();
        step();
        bif.src_address = 16'h9000; bif.dst_address = 16'h9100; bif.count = 16'd1;
        bif.start = 1;
        step();
        bif.start = 0;
        chk("ign_addr", 32'(bif.address), 32'h3001);
        chk("ign_we", 32'(bif.write_enable), 32'd1);
        step();
        chk("ign_rd", 32'(bif.address), 32'h2002);
        bif.abort = 1;
        step();
        bif.abort = 0;
        chk("abort_busy", 32'(bif.busy), 32'd0);
        chk("abort_be", 32'(bif.bus_enable), 32'd0);
        chk("abort_we", 32'(bif.write_enable), 32'd0);
        chk("abort_done", 32'(bif.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_nodone", 32'(bif.done), 32'd0);
            chk("abort_idle", 32'(bif.busy), 32'd0);
        end

        // reset during WRITE of word 2
        bif.src_address = 16'h0400; bif.dst_address = 16'h0500; bif.count = 16'd4;
        bif.start = 1;
        step();
        bif.start = 0;
        step(); step(); step();
        chk("mid_we", 32'(bif.write_enable), 32'd1);
        chk("mid_addr", 32'(bif.address), 32'h0501);
        #3 reset = 1'b0;
        #1;
        chk("mrst_busy", 32'(bif.busy), 32'd0);
        chk("mrst_be", 32'(bif.bus_enable), 32'd0);
        chk("mrst_we", 32'(bif.write_enable), 32'd0);
        chk("mrst_addr", 32'(bif.address), 32'd0);
        chk("mrst_dout", 32'(bif.data_out), 32'd0);
        chk("mrst_done", 32'(bif.done), 32'd0);
        @(posedge clk); #1;
        step();
        chk("mrst_hold", 32'(bif.busy), 32'd0);
        reset = 1'b1;
        run_copy(16'h0600, 16'h0700, 16'd1, 0, 0, n);
        chk("post_rst_cycles", 32'(n), 32'd3);

        // randomised copies, including overlapping ranges and random bus_ready
        for (int r = 0; r < 12; r++) begin
            s = 16'($urandom);
            c = 16'($urandom_range(1, 24));
            case (r % 3)
                0:       d = s + 16'($urandom_range(1, 4));
                1:       d = s - 16'($urandom_range(1, 4));
                default: d = 16'($urandom);
            endcase
            run_copy(s, d, c, (r % 4) != 0, 0, n);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
